// File: rtl/serial_sub_recover_if.sv
// Handshake and data bundle for the bit-serial subtractor that recovers b from the registered sum.
// The master drives the request and operands; the slave returns status and the result.
interface serial_sub_recover_if #(
    parameter int DATAWIDTH = 8
);
    logic                 start;
    logic [DATAWIDTH-1:0] c;
    logic [31:0]          a;
    logic                 busy;
    logic                 done;
    logic [15:0]          b;
    logic                 borrow;

    modport master (
        output start, c, a,
        input  busy, done, b, borrow
    );

    modport slave (
        input  start, c, a,
        output busy, done, b, borrow
    );
endinterface

// File: rtl/serial_sub_recover.sv
// Bit-serial subtractor: recovers b = c - a[DATAWIDTH-1:0] one bit per clock, LSB first,
// with a start/busy/done handshake and a zero-extended 16-bit result.
module serial_sub_recover #(
    parameter int DATAWIDTH = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    serial_sub_recover_if.slave bus
);
    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATAWIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_reg, state_next;
    logic [DATAWIDTH-1:0] c_sh_reg, c_sh_next;
    logic [DATAWIDTH-1:0] a_sh_reg, a_sh_next;
    logic [DATAWIDTH-1:0] diff_reg, diff_next;
    logic [DATAWIDTH-1:0] diff_shift;
    logic                 w_reg, w_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [15:0]          b_reg, b_next;
    logic                 borrow_reg, borrow_next;
    logic [15:0]          result_ext;
    logic                 x, y, dbit, w_new;
    logic                 unused_a_hi;

    // Only the low DATAWIDTH bits of the addend take part in the subtraction.
    assign unused_a_hi = ^bus.a;

    assign x     = c_sh_reg[0];
    assign y     = a_sh_reg[0];
    assign dbit  = x ^ y ^ w_reg;
    assign w_new = (~x & y) | (~(x ^ y) & w_reg);

    // The new difference bit enters at the MSB so the LSB-first stream lands in place.
    genvar gi;
    generate
        for (gi = 0; gi < DATAWIDTH; gi++) begin : g_diff
            if (gi == DATAWIDTH - 1) begin : g_top
                assign diff_shift[gi] = dbit;
            end else begin : g_low
                assign diff_shift[gi] = diff_reg[gi+1];
            end
        end
        for (gi = 0; gi < 16; gi++) begin : g_ext
            if (gi < DATAWIDTH) begin : g_data
                assign result_ext[gi] = diff_shift[gi];
            end else begin : g_zero
                assign result_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg  <= IDLE;
            c_sh_reg   <= '0;
            a_sh_reg   <= '0;
            diff_reg   <= '0;
            w_reg      <= 1'b0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            c_sh_reg   <= c_sh_next;
            a_sh_reg   <= a_sh_next;
            diff_reg   <= diff_next;
            w_reg      <= w_next;
            cnt_reg    <= cnt_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            b_reg      <= b_next;
            borrow_reg <= borrow_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        c_sh_next   = c_sh_reg;
        a_sh_next   = a_sh_reg;
        diff_next   = diff_reg;
        w_next      = w_reg;
        cnt_next    = cnt_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        b_next      = b_reg;
        borrow_next = borrow_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = SHIFT;
                    c_sh_next  = bus.c;
                    a_sh_next  = bus.a[DATAWIDTH-1:0];
                    w_next     = 1'b0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            SHIFT: begin
                c_sh_next = c_sh_reg >> 1;
                a_sh_next = a_sh_reg >> 1;
                diff_next = diff_shift;
                w_next    = w_new;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    state_next  = IDLE;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    b_next      = result_ext;
                    borrow_next = w_new;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.b      = b_reg;
    assign bus.borrow = borrow_reg;
endmodule

// File: tb/tb_serial_sub_recover.sv
// Self-checking bench for serial_sub_recover: directed cases, handshake, async reset,
// and a randomized round trip against an arithmetic reference.
module tb_serial_sub_recover;
    logic Clk = 1'b0;
    logic Rst = 1'b1;

    serial_sub_recover_if #(.DATAWIDTH(8)) bus ();

    serial_sub_recover #(.DATAWIDTH(8)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [7:0] cv, input logic [31:0] av,
                                  output logic [15:0] eb, output logic ebr);
        int d;
        d   = int'(cv) - int'(av & 32'hFF);
        ebr = (d < 0);
        if (d < 0) d += 256;
        eb  = 16'(d);
    endfunction

    // One complete operation; disturb changes inputs and re-pulses start mid-SHIFT.
    task automatic run_op(input logic [7:0] cv, input logic [31:0] av,
                          input logic [15:0] eb, input logic ebr,
                          input bit disturb, input string tag);
        int busy_cnt;
        bit seen;
        bit overlap;
        busy_cnt = 0;
        seen     = 0;
        overlap  = 0;
        @(negedge Clk);
        bus.c = cv; bus.a = av; bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.busy && bus.done) overlap = 1;
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (disturb && k == 3) begin
                bus.c = 8'($urandom); bus.a = $urandom; bus.start = 1'b1;
            end
            if (disturb && k == 4) bus.start = 1'b0;
            @(negedge Clk);
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "_b"}, 32'(bus.b), 32'(eb));
        chk({tag, "_borrow"}, 32'(bus.borrow), 32'(ebr));
        chk({tag, "_overlap"}, 32'(overlap), 32'd0);
        @(negedge Clk);
        chk({tag, "_done_single"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0]  cv;
        logic [31:0] av;
        logic [15:0] b0, eb;
        logic        ebr;
        logic [15:0] qb[$];
        logic        qbr[$];
        int          cyc, last, got, dcount;

        bus.start = 1'b0; bus.c = '0; bus.a = '0;
        @(negedge Clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_b", 32'(bus.b), 32'd0);
        chk("reset_borrow", 32'(bus.borrow), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;

        run_op(8'h2D, 32'h00000017, 16'h0016, 1'b0, 0, "basic");
        run_op(8'h05, 32'h0000000A, 16'h00FB, 1'b1, 0, "underflow");
        run_op(8'h00, 32'h00000001, 16'h00FF, 1'b1, 0, "zero_minus_one");
        run_op(8'hFF, 32'h000000FF, 16'h0000, 1'b0, 0, "ff_minus_ff");
        run_op(8'h10, 32'hFFFFFF10, 16'h0000, 1'b0, 0, "upper_mask");
        run_op(8'hA5, 32'h1234563C, 16'h0069, 1'b0, 1, "capture_ignore");

        // Start held high: one result every 9 cycles, operands taken at each accept edge.
        @(negedge Clk);
        cv = 8'($urandom); av = $urandom;
        bus.c = cv; bus.a = av; bus.start = 1'b1;
        model(cv, av, eb, ebr); qb.push_back(eb); qbr.push_back(ebr);
        cyc = 0; last = 0; got = 0;
        for (int t = 0; t < 200 && got < 6; t++) begin
            @(negedge Clk);
            cyc++;
            if (bus.done) begin
                chk("stream_b", 32'(bus.b), 32'(qb.pop_front()));
                chk("stream_borrow", 32'(bus.borrow), 32'(qbr.pop_front()));
                if (got > 0) chk("stream_interval", 32'(cyc - last), 32'd9);
                last = cyc;
                got++;
                if (got < 6) begin
                    cv = 8'($urandom); av = $urandom;
                    bus.c = cv; bus.a = av;
                    model(cv, av, eb, ebr); qb.push_back(eb); qbr.push_back(ebr);
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                bus.c = 8'($urandom); bus.a = $urandom;
            end
        end
        chk("stream_count", 32'(got), 32'd6);
        repeat (2) @(negedge Clk);

        // Asynchronous reset during the 4th SHIFT cycle.
        run_op(8'h05, 32'h0000000A, 16'h00FB, 1'b1, 0, "pre_reset");
        @(negedge Clk);
        bus.c = 8'h77; bus.a = 32'h11; bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        chk("async_rst_b", 32'(bus.b), 32'd0);
        chk("async_rst_borrow", 32'(bus.borrow), 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge Clk);
            if (bus.done) dcount++;
        end
        chk("no_done_after_abort", 32'(dcount), 32'd0);
        run_op(8'h2D, 32'h00000017, 16'h0016, 1'b0, 0, "post_reset");

        // Round trip against the adder: c = (a + b0) mod 256 must give back b0's low byte.
        for (int i = 0; i < 1000; i++) begin
            av = $urandom;
            b0 = 16'($urandom);
            cv = 8'((av + 32'(b0)) & 32'hFF);
            run_op(cv, av, b0 & 16'h00FF, (cv < av[7:0]), (i % 50) == 0, "roundtrip");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
